// File: rtl/puf_seq_pkg.sv
// puf_seq_pkg
//   Shared definitions for the PUF evaluation sequencer: FSM state encoding,
//   vote-counter width helper and default parameter values.
package puf_seq_pkg;

   localparam int DEF_CHALLENGE_WIDTH  = 64;
   localparam int DEF_PDL_CONFIG_WIDTH = 128;
   localparam int DEF_RESPONSE_WIDTH   = 6;
   localparam int DEF_SETTLE_CYCLES    = 15;
   localparam int DEF_NUM_EVAL         = 7;

   // Sized for the largest legal values (NUM_EVAL <= 15, SETTLE_CYCLES <= 255).
   localparam int EVAL_CNT_W   = 4;
   localparam int SETTLE_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      FIRE,
      DECIDE,
      REPORT
   } seq_state_t;

   // Enough bits to count 0..num_eval ones.
   function automatic int vote_width(input int num_eval);
      return $clog2(num_eval + 1);
   endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// puf_majority_voter
//   Synchronizes the asynchronous PUF responses, counts ones per bit across
//   evaluations and produces the majority vote plus a unanimity flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clear               zero all ones counters (new command)
//   accumulate          add the synchronized sample to the counters
//   decide              register voted bits and the stable flag
//   raw_response        asynchronous raw PUF response
//   xor_response        asynchronous xor PUF response
//   voted_raw/voted_xor registered majority results
//   stable              every bit was unanimous across all evaluations
module puf_majority_voter
   import puf_seq_pkg::*;
#(
   parameter int RESPONSE_WIDTH = DEF_RESPONSE_WIDTH,
   parameter int NUM_EVAL       = DEF_NUM_EVAL
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      accumulate,
   input  logic                      decide,
   input  logic [RESPONSE_WIDTH-1:0] raw_response,
   input  logic                      xor_response,
   output logic [RESPONSE_WIDTH-1:0] voted_raw,
   output logic                      voted_xor,
   output logic                      stable
);

   localparam int CW = vote_width(NUM_EVAL);
   localparam int NB = RESPONSE_WIDTH + 1;   // raw bits plus the xor bit on top

   logic [NB-1:0] sync_1;
   logic [NB-1:0] sync_2;
   logic [CW-1:0] ones_cnt [NB];
   logic [NB-1:0] vote;
   logic [NB-1:0] unanimous;

   always_comb begin
      vote      = '0;
      unanimous = '0;
      for (int i = 0; i < NB; i++) begin
         vote[i]      = (ones_cnt[i] > CW'(NUM_EVAL / 2));
         unanimous[i] = (ones_cnt[i] == '0) || (ones_cnt[i] == CW'(NUM_EVAL));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1    <= '0;
         sync_2    <= '0;
         for (int i = 0; i < NB; i++) ones_cnt[i] <= '0;
         voted_raw <= '0;
         voted_xor <= 1'b0;
         stable    <= 1'b0;
      end else begin
         sync_1 <= {xor_response, raw_response};
         sync_2 <= sync_1;
         if (clear) begin
            for (int i = 0; i < NB; i++) ones_cnt[i] <= '0;
         end else if (accumulate) begin
            for (int i = 0; i < NB; i++) ones_cnt[i] <= ones_cnt[i] + CW'(sync_2[i]);
         end
         if (decide) begin
            voted_raw <= vote[RESPONSE_WIDTH-1:0];
            voted_xor <= vote[RESPONSE_WIDTH];
            stable    <= &unanimous;
         end
      end
   end

endmodule

// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer
//   Host-side initiator for the PUF datapath. On an accepted command it latches
//   challenge and PDL config, runs NUM_EVAL arm/fire evaluations, majority-votes
//   the responses and returns the result through a valid/ack handshake.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_start/cmd_challenge/
//   cmd_pdl_config                   host command (accepted only when idle)
//   busy                             command in progress until ack consumed
//   result_valid/result_ack          result handshake
//   result_raw/result_xor/
//   result_stable                    voted result and unanimity flag
//   puf_challenge/puf_pdl_config     latched command to the PUF
//   puf_trigger/puf_reset            PUF launch and arbiter clear
//   puf_raw_response/puf_xor_response asynchronous PUF responses
//
// state  | meaning
// IDLE   | waiting for cmd_start; PUF held in reset
// ARM    | one cycle of arbiter clear before a launch
// FIRE   | SETTLE_CYCLES of trigger high; sample on the last cycle
// DECIDE | one cycle to register the majority vote
// REPORT | result_valid high until result_ack
module puf_eval_sequencer
   import puf_seq_pkg::*;
#(
   parameter int CHALLENGE_WIDTH  = DEF_CHALLENGE_WIDTH,
   parameter int PDL_CONFIG_WIDTH = DEF_PDL_CONFIG_WIDTH,
   parameter int RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
   parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
   parameter int NUM_EVAL         = DEF_NUM_EVAL
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_start,
   input  logic [CHALLENGE_WIDTH-1:0]  cmd_challenge,
   input  logic [PDL_CONFIG_WIDTH-1:0] cmd_pdl_config,
   output logic                        busy,
   output logic                        result_valid,
   input  logic                        result_ack,
   output logic [RESPONSE_WIDTH-1:0]   result_raw,
   output logic                        result_xor,
   output logic                        result_stable,
   output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
   output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
   output logic                        puf_trigger,
   output logic                        puf_reset,
   input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
   input  logic                        puf_xor_response
);

   if ((NUM_EVAL % 2) == 0 || NUM_EVAL < 1 || NUM_EVAL > 15) begin : g_bad_num_eval
      $error("puf_eval_sequencer: NUM_EVAL must be odd and within 1..15");
   end
   if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("puf_eval_sequencer: SETTLE_CYCLES must be within 3..255");
   end

   seq_state_t              state;
   logic [SETTLE_CNT_W-1:0] settle_timer;
   logic [EVAL_CNT_W-1:0]   eval_cnt;

   logic accept;
   logic last_fire;
   logic in_decide;

   assign accept    = (state == IDLE) && cmd_start;
   assign last_fire = (state == FIRE) && (settle_timer == '0);
   assign in_decide = (state == DECIDE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         result_valid   <= 1'b0;
         puf_trigger    <= 1'b0;
         puf_reset      <= 1'b1;
         puf_challenge  <= '0;
         puf_pdl_config <= '0;
         settle_timer   <= '0;
         eval_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  puf_challenge  <= cmd_challenge;
                  puf_pdl_config <= cmd_pdl_config;
                  eval_cnt       <= '0;
                  busy           <= 1'b1;
                  state          <= ARM;
               end
            end
            ARM: begin
               puf_reset    <= 1'b0;
               puf_trigger  <= 1'b1;
               settle_timer <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
               state        <= FIRE;
            end
            FIRE: begin
               if (settle_timer == '0) begin
                  puf_trigger <= 1'b0;
                  puf_reset   <= 1'b1;
                  eval_cnt    <= eval_cnt + EVAL_CNT_W'(1);
                  if (eval_cnt == EVAL_CNT_W'(NUM_EVAL - 1)) state <= DECIDE;
                  else                                       state <= ARM;
               end else begin
                  settle_timer <= settle_timer - SETTLE_CNT_W'(1);
               end
            end
            DECIDE: begin
               result_valid <= 1'b1;
               state        <= REPORT;
            end
            REPORT: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   puf_majority_voter #(
      .RESPONSE_WIDTH (RESPONSE_WIDTH),
      .NUM_EVAL       (NUM_EVAL)
   ) u_voter (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .accumulate   (last_fire),
      .decide       (in_decide),
      .raw_response (puf_raw_response),
      .xor_response (puf_xor_response),
      .voted_raw    (result_raw),
      .voted_xor    (result_xor),
      .stable       (result_stable)
   );

endmodule
